paddle_cmd_arbiter: RTL and testbench

Sequences the debounced paddle buttons of both players into a single stream of paddle-move commands for the game logic. Each player's up/down level is resolved, turned into a press event, optionally auto-repeated while held, and the two players share one valid/ready command port through round-robin arbitration. Sits between the per-button debounce stage and the paddle position logic in the CONTROLLER.

---
 rtl/paddle_pkg.sv | 29 ++
 rtl/paddle_repeat.sv | 122 ++++++++++++
 rtl/paddle_cmd_arbiter.sv | 91 +++++++++
 tb/tb_paddle_cmd_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types for the paddle command arbiter. The FSM state set depends on
// PADDLE_AUTOREPEAT_EN (auto-repeat states vs. a simple held state).
package paddle_pkg;

  localparam int NUM_PLAYERS = 2;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

`ifdef PADDLE_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1
  } state_t;
`endif

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/paddle_repeat.sv
// Per-player direction resolve, press/repeat FSM and single-bit pending event.
// With PADDLE_AUTOREPEAT_EN undefined there is no counter: one event per press.
module paddle_repeat
  import paddle_pkg::*;
`ifdef PADDLE_AUTOREPEAT_EN
#(
  parameter int REPEAT_DLY = 32,
  parameter int REPEAT_PER = 32
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic up,
  input  logic dn,
  input  logic clr,
  output logic pending,
  output dir_t pend_dir
);

  logic   active;
  dir_t   dir;
  state_t state;

  assign active = up ^ dn;
  assign dir    = up ? DIR_UP : DIR_DN;

`ifdef PADDLE_AUTOREPEAT_EN
  localparam int CNT_W = $clog2(max_int(REPEAT_DLY, REPEAT_PER));
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

  logic [CNT_W-1:0] cnt;

  // Press/delay/repeat sequencing; a new event set overrides a same-cycle grant clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= 1'b0;
      pend_dir <= DIR_DN;
    end else begin
      if (clr) begin
        pending <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (active) begin
            state    <= DELAY;
            pending  <= 1'b1;
            pend_dir <= dir;
          end else begin
            pending <= 1'b0;
          end
        end
        DELAY, REPEAT: begin
          if (!active) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
          end else if (dir != pend_dir) begin
            state    <= DELAY;
            cnt      <= '0;
            pending  <= 1'b1;
            pend_dir <= dir;
          end else if (cnt == ((state == DELAY) ? DLY_LAST : PER_LAST)) begin
            state   <= REPEAT;
            cnt     <= '0;
            pending <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          pending <= 1'b0;
        end
      endcase
    end
  end
`else
  // One event per press or direction change; release drops any stale event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      pend_dir <= DIR_DN;
    end else begin
      if (clr) begin
        pending <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (active) begin
            state    <= HELD;
            pending  <= 1'b1;
            pend_dir <= dir;
          end else begin
            pending <= 1'b0;
          end
        end
        HELD: begin
          if (!active) begin
            state   <= IDLE;
            pending <= 1'b0;
          end else if (dir != pend_dir) begin
            pending  <= 1'b1;
            pend_dir <= dir;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: rtl/paddle_cmd_arbiter.sv
// Two-player paddle command sequencer: input register, per-player repeat FSMs,
// round-robin grant into a valid/ready output register. Auto-repeat: PADDLE_AUTOREPEAT_EN.
module paddle_cmd_arbiter
  import paddle_pkg::*;
#(
  parameter int REPEAT_DLY = 32,
  parameter int REPEAT_PER = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_up,
  input  logic [1:0] btn_dn,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_player,
  output logic       cmd_dir
);

  logic [NUM_PLAYERS-1:0] up_q;
  logic [NUM_PLAYERS-1:0] dn_q;
  logic [NUM_PLAYERS-1:0] pending;
  logic [NUM_PLAYERS-1:0] clr;
  dir_t                   pend_dir [NUM_PLAYERS];
  logic                   rr_ptr;
  logic                   load;
  logic                   grant_any;
  logic                   grant_player;

  // Single input register stage in front of the FSMs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_q <= 2'b00;
      dn_q <= 2'b00;
    end else begin
      up_q <= btn_up;
      dn_q <= btn_dn;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign clr[p] = load & grant_any & (grant_player == 1'(p));

    paddle_repeat
`ifdef PADDLE_AUTOREPEAT_EN
    #(
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
    )
`endif
    u_repeat (
      .clk     (clk),
      .rst     (rst),
      .up      (up_q[p]),
      .dn      (dn_q[p]),
      .clr     (clr[p]),
      .pending (pending[p]),
      .pend_dir(pend_dir[p])
    );
  end

  // Grant selection: round-robin only matters when both players are pending.
  always_comb begin
    load      = !cmd_valid || cmd_ready;
    grant_any = |pending;
    if (&pending) begin
      grant_player = rr_ptr;
    end else begin
      grant_player = pending[1];
    end
  end

  // Output register; contents are frozen while a command waits for ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_valid  <= 1'b0;
      cmd_player <= 1'b0;
      cmd_dir    <= 1'b0;
      rr_ptr     <= 1'b0;
    end else if (load) begin
      if (grant_any) begin
        cmd_valid  <= 1'b1;
        cmd_player <= grant_player;
        cmd_dir    <= pend_dir[grant_player];
        rr_ptr     <= ~grant_player;
      end else begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_paddle_cmd_arbiter.sv
// Directed bench for paddle_cmd_arbiter (REPEAT_DLY=8, REPEAT_PER=4); expectations
// follow PADDLE_AUTOREPEAT_EN so either build can be checked.
module tb_paddle_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn_up = 2'b00;
  logic [1:0] btn_dn = 2'b00;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic       cmd_player;
  logic       cmd_dir;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int t0;

  int log_cyc[$];
  bit log_p[$];
  bit log_d[$];
  int exp_cyc[$];
  bit exp_p[$];
  bit exp_d[$];

  paddle_cmd_arbiter #(
    .REPEAT_DLY(8),
    .REPEAT_PER(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_player(cmd_player),
    .cmd_dir   (cmd_dir)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted command with the edge count at which it was visible.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      log_cyc.push_back(cyc);
      log_p.push_back(cmd_player);
      log_d.push_back(cmd_dir);
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input int at, input bit p, input bit d);
    exp_cyc.push_back(at);
    exp_p.push_back(p);
    exp_d.push_back(d);
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, " count"}, log_cyc.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < log_cyc.size(); i++) begin
      check_eq($sformatf("%s cmd%0d cycle", tag, i), log_cyc[i], exp_cyc[i]);
      check_eq($sformatf("%s cmd%0d player/dir", tag, i),
               int'({log_p[i], log_d[i]}), int'({exp_p[i], exp_d[i]}));
    end
    log_cyc.delete();
    log_p.delete();
    log_d.delete();
    exp_cyc.delete();
    exp_p.delete();
    exp_d.delete();
  endtask

  initial begin
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2);
    check_eq("reset cmd_valid", int'(cmd_valid), 0);
    check_eq("reset cmd_player", int'(cmd_player), 0);
    check_eq("reset cmd_dir", int'(cmd_dir), 0);

    // Short pulse: one command, two edges after capture.
    cmd_ready = 1'b1;
    log_cyc.delete(); log_p.delete(); log_d.delete();
    t0 = cyc;
    btn_up = 2'b01;
    wait_cycles(3);
    btn_up = 2'b00;
    wait_cycles(15);
    expect_cmd(t0 + 3, 1'b0, 1'b1);
    check_log("pulse");

    // Player 1 holds down for 20 cycles.
    t0 = cyc;
    btn_dn = 2'b10;
    wait_cycles(20);
    btn_dn = 2'b00;
    wait_cycles(10);
    expect_cmd(t0 + 3, 1'b1, 1'b0);
`ifdef PADDLE_AUTOREPEAT_EN
    expect_cmd(t0 + 11, 1'b1, 1'b0);
    expect_cmd(t0 + 15, 1'b1, 1'b0);
    expect_cmd(t0 + 19, 1'b1, 1'b0);
`endif
    check_log("hold p1");

    // Simultaneous presses: round-robin ordering.
    t0 = cyc;
    btn_up = 2'b01;
    btn_dn = 2'b10;
    wait_cycles(11);
    btn_up = 2'b00;
    btn_dn = 2'b00;
    wait_cycles(10);
    expect_cmd(t0 + 3, 1'b0, 1'b1);
    expect_cmd(t0 + 4, 1'b1, 1'b0);
`ifdef PADDLE_AUTOREPEAT_EN
    expect_cmd(t0 + 11, 1'b0, 1'b1);
    expect_cmd(t0 + 12, 1'b1, 1'b0);
`endif
    check_log("both");

    // Back-pressure: output held stable, repeats coalesce into one command.
    cmd_ready = 1'b0;
    t0 = cyc;
    btn_up = 2'b01;
    wait_cycles(3);
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("stall hold %0d", i), int'({cmd_valid, cmd_player, cmd_dir}), 5);
      wait_cycles(1);
    end
    cmd_ready = 1'b1;
    wait_cycles(1);
    btn_up = 2'b00;
    wait_cycles(10);
    expect_cmd(t0 + 14, 1'b0, 1'b1);
`ifdef PADDLE_AUTOREPEAT_EN
    expect_cmd(t0 + 15, 1'b0, 1'b1);
`endif
    check_log("stall");

    // Up and down together resolve to no direction.
    btn_up = 2'b01;
    btn_dn = 2'b01;
    wait_cycles(6);
    btn_up = 2'b00;
    btn_dn = 2'b00;
    wait_cycles(6);
    check_log("both dirs");

    // Direction switch while held restarts the delay.
    t0 = cyc;
    btn_up = 2'b01;
    wait_cycles(4);
    btn_up = 2'b00;
    btn_dn = 2'b01;
    wait_cycles(11);
    btn_dn = 2'b00;
    wait_cycles(10);
    expect_cmd(t0 + 3, 1'b0, 1'b1);
    expect_cmd(t0 + 7, 1'b0, 1'b0);
`ifdef PADDLE_AUTOREPEAT_EN
    expect_cmd(t0 + 15, 1'b0, 1'b0);
`endif
    check_log("switch");

`ifndef PADDLE_AUTOREPEAT_EN
    // Long hold without auto-repeat: exactly one command.
    t0 = cyc;
    btn_up = 2'b01;
    wait_cycles(50);
    btn_up = 2'b00;
    wait_cycles(5);
    expect_cmd(t0 + 3, 1'b0, 1'b1);
    check_log("long hold");
`endif

    // Reset mid-hold drops the stalled command; held button re-presses after release.
    cmd_ready = 1'b0;
    btn_up = 2'b01;
    wait_cycles(5);
    check_eq("pre-reset valid", int'(cmd_valid), 1);
    rst = 1'b0;
    #1;
    check_eq("async reset valid", int'(cmd_valid), 0);
    wait_cycles(2);
    rst = 1'b1;
    cmd_ready = 1'b1;
    t0 = cyc;
    wait_cycles(6);
    btn_up = 2'b00;
    wait_cycles(10);
    expect_cmd(t0 + 3, 1'b0, 1'b1);
    check_log("post reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
